pe_image_packetizer: RTL and testbench

//   Upstream feeder of the region-growing PE: frames a raster RGB pixel stream into one NoC packet.

---
 rtl/pe_image_packetizer.sv | 181 ++++++++++++++++++
 tb/tb_pe_image_packetizer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_image_packetizer.sv
// Frames a raster RGB pixel stream into one NoC packet: head flit, one body flit per pixel,
// and a tail flit carrying the R+G+B checksum. A small skid FIFO decouples input from output.
module pe_image_packetizer #(
  parameter int unsigned ROWS       = 273,
  parameter int unsigned COLS       = 182,
  parameter int unsigned X          = 3,
  parameter int unsigned Y          = 3,
  parameter int unsigned PKT_NO_W   = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned X_SIZE    = $clog2(X),
  localparam int unsigned Y_SIZE    = $clog2(Y),
  localparam int unsigned TOTAL_W   = X_SIZE + Y_SIZE + PKT_NO_W + ID_W + DATA_W
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [X_SIZE-1:0]   dest_x,
  input  logic [Y_SIZE-1:0]   dest_y,
  input  logic [PKT_NO_W-1:0] pkt_no,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  output logic                w_valid_pe,
  input  logic                w_ready_pe,
  output logic [TOTAL_W-1:0]  w_data_pe,
  output logic                busy,
  output logic                done
);

  localparam int unsigned NPIX  = ROWS * COLS;
  localparam int unsigned CNT_W = $clog2(NPIX + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] NPIX_C   = CNT_W'(NPIX);
  localparam logic [15:0]      NPIX16   = 16'(NPIX);
  localparam logic [ID_W-1:0]  TYPE_HEAD = ID_W'(0);
  localparam logic [ID_W-1:0]  TYPE_BODY = ID_W'(1);
  localparam logic [ID_W-1:0]  TYPE_TAIL = ID_W'(3);

  typedef enum logic [1:0] {StIdle, StHead, StBody, StTail} state_t;

  state_t                r_state;
  logic [X_SIZE-1:0]     r_dest_x;
  logic [Y_SIZE-1:0]     r_dest_y;
  logic [PKT_NO_W-1:0]   r_pkt_no;
  logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W:0]        r_wptr;
  logic [PTR_W:0]        r_rptr;
  logic [CNT_W-1:0]      r_in_cnt;
  logic [CNT_W-1:0]      r_out_cnt;
  logic [DATA_W-1:0]     r_csum;
  logic                  r_valid;
  logic [TOTAL_W-1:0]    r_data;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_slot_free;
  logic                  w_body_phase;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_in_phase;
  logic [DATA_W-1:0]     w_pix_sum;
  logic [DATA_W-1:0]     w_fifo_head;

  function automatic logic [TOTAL_W-1:0] mk_flit(input logic [X_SIZE-1:0]   dx,
                                                 input logic [Y_SIZE-1:0]   dy,
                                                 input logic [PKT_NO_W-1:0] pn,
                                                 input logic [ID_W-1:0]     ty,
                                                 input logic [DATA_W-1:0]   pl);
    return {dx, dy, pn, ty, pl};
  endfunction

  assign w_empty      = (r_wptr == r_rptr);
  assign w_full       = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                        (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_slot_free  = !r_valid || w_ready_pe;
  // The head handshake cycle may already pull the first pixel, keeping flits back-to-back.
  assign w_body_phase = (r_state == StBody) || ((r_state == StHead) && w_ready_pe);
  assign w_pop        = w_body_phase && w_slot_free && !w_empty && (r_out_cnt != NPIX_C);
  assign w_in_phase   = (r_state == StHead) || (r_state == StBody);
  assign s_ready      = (!w_full || w_pop) && w_in_phase && (r_in_cnt != NPIX_C);
  assign w_push       = s_valid && s_ready;
  assign w_pix_sum    = DATA_W'(s_data[23:16]) + DATA_W'(s_data[15:8]) + DATA_W'(s_data[7:0]);
  assign w_fifo_head  = r_mem[r_rptr[PTR_W-1:0]];

  assign w_valid_pe = r_valid;
  assign w_data_pe  = r_data;
  assign busy       = r_busy;
  assign done       = r_done;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[PTR_W-1:0]] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= StIdle;
      r_dest_x  <= '0;
      r_dest_y  <= '0;
      r_pkt_no  <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_csum    <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_push) begin
        r_wptr   <= r_wptr + 1'b1;
        r_in_cnt <= r_in_cnt + 1'b1;
        r_csum   <= r_csum + w_pix_sum;
      end
      if (w_pop) begin
        r_rptr    <= r_rptr + 1'b1;
        r_out_cnt <= r_out_cnt + 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_dest_x  <= dest_x;
            r_dest_y  <= dest_y;
            r_pkt_no  <= pkt_no;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_csum    <= '0;
            r_valid   <= 1'b1;
            r_data    <= mk_flit(dest_x, dest_y, pkt_no, TYPE_HEAD, DATA_W'(NPIX16));
            r_busy    <= 1'b1;
            r_state   <= StHead;
          end
        end
        StHead: begin
          if (w_ready_pe) begin
            r_state <= StBody;
            if (w_pop) begin
              r_data <= mk_flit(r_dest_x, r_dest_y, r_pkt_no, TYPE_BODY, w_fifo_head);
            end else begin
              r_valid <= 1'b0;
            end
          end
        end
        StBody: begin
          if (w_slot_free) begin
            if (w_pop) begin
              r_valid <= 1'b1;
              r_data  <= mk_flit(r_dest_x, r_dest_y, r_pkt_no, TYPE_BODY, w_fifo_head);
            end else if (r_out_cnt == NPIX_C) begin
              // Every pixel has been pushed a cycle earlier at least, so the checksum is final.
              r_valid <= 1'b1;
              r_data  <= mk_flit(r_dest_x, r_dest_y, r_pkt_no, TYPE_TAIL, r_csum);
              r_state <= StTail;
            end else begin
              r_valid <= 1'b0;
            end
          end
        end
        StTail: begin
          if (w_ready_pe) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_image_packetizer.sv
// Directed bench for pe_image_packetizer on a 2x3 image: basic framing, stalls, ignored start,
// surplus pixels and mid-packet reset.
module tb_pe_image_packetizer;

  localparam int unsigned ROWS = 2;
  localparam int unsigned COLS = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [1:0]  dest_x;
  logic [1:0]  dest_y;
  logic [3:0]  pkt_no;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        w_valid_pe;
  logic        w_ready_pe;
  logic [33:0] w_data_pe;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [33:0] q[$];
  bit          prev_stall = 1'b0;
  logic [33:0] prev_data  = '0;
  int          stall_acc;
  bit          stall_rdy_end;
  int          extra_acc;
  int          accepted;

  pe_image_packetizer #(
    .ROWS(ROWS), .COLS(COLS), .X(3), .Y(3), .PKT_NO_W(4), .ID_W(2), .DATA_W(24), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .dest_x(dest_x), .dest_y(dest_y), .pkt_no(pkt_no),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .w_valid_pe(w_valid_pe),
    .w_ready_pe(w_ready_pe), .w_data_pe(w_data_pe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input int i);
    logic [7:0] a;
    a = 8'(i + 1);
    return {a, a + 8'd1, a + 8'd2};
  endfunction

  function automatic logic [33:0] exp_flit(input int k, input logic [1:0] dx, input logic [1:0] dy,
                                           input logic [3:0] pn);
    if (k == 0) return {dx, dy, pn, 2'b00, 24'h000006};
    if (k <= 6) return {dx, dy, pn, 2'b01, pix(k - 1)};
    return {dx, dy, pn, 2'b11, 24'h000051};
  endfunction

  // Flit collector; also checks that a stalled flit is held unchanged.
  always @(negedge clk) begin
    #4;
    if (rstn === 1'b1) begin
      if (prev_stall) begin
        total++;
        if (w_valid_pe !== 1'b1 || w_data_pe !== prev_data) begin
          bad++;
          $display("FAIL stall_hold: got v=%b d=%h want v=1 d=%h", w_valid_pe, w_data_pe,
                   prev_data);
        end
      end
      if (w_valid_pe === 1'b1 && w_ready_pe === 1'b1) q.push_back(w_data_pe);
      prev_stall = (w_valid_pe === 1'b1) && (w_ready_pe === 1'b0);
      prev_data  = w_data_pe;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic start_pkt(input logic [1:0] dx, input logic [1:0] dy, input logic [3:0] pn);
    @(negedge clk);
    w_ready_pe = 1'b0;
    s_valid    = 1'b0;
    start      = 1'b1;
    dest_x     = dx;
    dest_y     = dy;
    pkt_no     = pn;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ready_mode: 0 always ready, 1 toggling 1010, 2 ready only in cycle 0 and from cycle 11.
  task automatic drive_stream(input int ready_mode, input bit gaps, input int start_at,
                              input int n_offer, input int target, output bit timed_out);
    int idx = 0;
    int cyc = 0;
    stall_acc     = 0;
    stall_rdy_end = 1'b1;
    extra_acc     = 0;
    forever begin
      @(negedge clk);
      if (q.size() >= target || cyc >= 100) break;
      case (ready_mode)
        0:       w_ready_pe = 1'b1;
        1:       w_ready_pe = (cyc % 2 == 0);
        default: w_ready_pe = (cyc == 0 || cyc >= 11);
      endcase
      start = (cyc == start_at);
      if (start) begin
        dest_x = 2'd1;
        dest_y = 2'd2;
        pkt_no = 4'd15;
      end
      s_valid = (idx < n_offer) && !(gaps && (cyc % 3 == 2));
      s_data  = pix(idx);
      #3;
      if (s_valid && s_ready) begin
        if (idx >= 6) extra_acc++;
        if (ready_mode == 2 && cyc >= 1 && cyc <= 10) stall_acc++;
        idx++;
      end
      if (ready_mode == 2 && cyc == 10) stall_rdy_end = s_ready;
      cyc++;
    end
    s_valid   = 1'b0;
    start     = 1'b0;
    accepted  = idx;
    timed_out = (q.size() < target);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start      = c[0];
      s_valid    = ~c[0];
      w_ready_pe = c[0];
      s_data     = 24'hABCDEF;
      dest_x     = 2'd3;
      pkt_no     = 4'(c);
      #4;
      total++;
      if ({s_ready, w_valid_pe, busy, done} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_ctrl: got rdy/v/busy/done=%b want 0000",
                 {s_ready, w_valid_pe, busy, done});
      end
      total++;
      if (w_data_pe !== 34'h0) begin
        bad++;
        $display("FAIL reset_data: got %h want 0", w_data_pe);
      end
    end
    @(negedge clk);
    start      = 1'b0;
    s_valid    = 1'b0;
    w_ready_pe = 1'b0;
    rstn       = 1'b1;
  endtask

  task automatic test_basic();
    bit to;
    q.delete();
    start_pkt(2'd2, 2'd1, 4'd5);
    #1;
    total++;
    if (busy !== 1'b1 || w_valid_pe !== 1'b1 || w_data_pe !== exp_flit(0, 2'd2, 2'd1, 4'd5)) begin
      bad++;
      $display("FAIL head_latency: got busy=%b v=%b d=%h want 1 1 %h", busy, w_valid_pe,
               w_data_pe, exp_flit(0, 2'd2, 2'd1, 4'd5));
    end
    drive_stream(0, 1'b0, -1, 6, 8, to);
    total++;
    if (to || q.size() != 8) begin
      bad++;
      $display("FAIL basic_count: got %0d flits want 8", q.size());
    end
    for (int k = 0; k < 8 && k < q.size(); k++) begin
      total++;
      if (q[k] !== exp_flit(k, 2'd2, 2'd1, 4'd5)) begin
        bad++;
        $display("FAIL basic_flit%0d: got %h want %h", k, q[k], exp_flit(k, 2'd2, 2'd1, 4'd5));
      end
    end
    #4;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || w_valid_pe !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse: got done=%b busy=%b v=%b want 1 0 0", done, busy, w_valid_pe);
    end
    @(negedge clk);
    #4;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_single: got done=%b want 0", done);
    end
  endtask

  task automatic test_toggle_gaps();
    bit to;
    q.delete();
    start_pkt(2'd2, 2'd1, 4'd5);
    drive_stream(1, 1'b1, -1, 6, 8, to);
    total++;
    if (to || q.size() != 8) begin
      bad++;
      $display("FAIL toggle_count: got %0d flits want 8", q.size());
    end
    for (int k = 0; k < 8 && k < q.size(); k++) begin
      total++;
      if (q[k] !== exp_flit(k, 2'd2, 2'd1, 4'd5)) begin
        bad++;
        $display("FAIL toggle_flit%0d: got %h want %h", k, q[k], exp_flit(k, 2'd2, 2'd1, 4'd5));
      end
    end
    #4;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL toggle_done: got %b want 1", done);
    end
  endtask

  task automatic test_back_to_back_stall();
    bit to;
    q.delete();
    start_pkt(2'd2, 2'd1, 4'd5);
    drive_stream(2, 1'b0, -1, 6, 8, to);
    total++;
    if (stall_acc != 4) begin
      bad++;
      $display("FAIL stall_accepts: got %0d want 4", stall_acc);
    end
    total++;
    if (stall_rdy_end !== 1'b0) begin
      bad++;
      $display("FAIL stall_s_ready: got %b want 0", stall_rdy_end);
    end
    total++;
    if (to || q.size() != 8) begin
      bad++;
      $display("FAIL stall_count: got %0d flits want 8", q.size());
    end
    for (int k = 0; k < 8 && k < q.size(); k++) begin
      total++;
      if (q[k] !== exp_flit(k, 2'd2, 2'd1, 4'd5)) begin
        bad++;
        $display("FAIL stall_flit%0d: got %h want %h", k, q[k], exp_flit(k, 2'd2, 2'd1, 4'd5));
      end
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    q.delete();
    start_pkt(2'd2, 2'd1, 4'd5);
    drive_stream(0, 1'b0, 3, 7, 8, to);
    total++;
    if (extra_acc != 0 || accepted != 6) begin
      bad++;
      $display("FAIL surplus_pixel: got accepted=%0d extra=%0d want 6 0", accepted, extra_acc);
    end
    total++;
    if (to || q.size() != 8) begin
      bad++;
      $display("FAIL ignore_count: got %0d flits want 8", q.size());
    end
    for (int k = 0; k < 8 && k < q.size(); k++) begin
      total++;
      if (q[k] !== exp_flit(k, 2'd2, 2'd1, 4'd5)) begin
        bad++;
        $display("FAIL ignore_flit%0d: got %h want %h", k, q[k], exp_flit(k, 2'd2, 2'd1, 4'd5));
      end
    end
    repeat (3) @(negedge clk);
    #4;
    total++;
    if (w_valid_pe !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_idle: got v=%b busy=%b want 0 0", w_valid_pe, busy);
    end
  endtask

  task automatic test_mid_reset();
    bit to;
    q.delete();
    start_pkt(2'd2, 2'd1, 4'd5);
    drive_stream(0, 1'b0, -1, 6, 4, to);
    rstn = 1'b0;
    #1;
    total++;
    if ({s_ready, w_valid_pe, busy, done} !== 4'b0000 || w_data_pe !== 34'h0) begin
      bad++;
      $display("FAIL midreset_out: got rdy/v/busy/done=%b d=%h want 0000 0",
               {s_ready, w_valid_pe, busy, done}, w_data_pe);
    end
    @(negedge clk);
    rstn = 1'b1;
    q.delete();
    start_pkt(2'd1, 2'd2, 4'd9);
    #1;
    total++;
    if (w_valid_pe !== 1'b1 || w_data_pe !== exp_flit(0, 2'd1, 2'd2, 4'd9)) begin
      bad++;
      $display("FAIL midreset_head: got v=%b d=%h want 1 %h", w_valid_pe, w_data_pe,
               exp_flit(0, 2'd1, 2'd2, 4'd9));
    end
    drive_stream(0, 1'b0, -1, 6, 8, to);
    total++;
    if (to || q.size() != 8) begin
      bad++;
      $display("FAIL midreset_count: got %0d flits want 8", q.size());
    end
    for (int k = 0; k < 8 && k < q.size(); k++) begin
      total++;
      if (q[k] !== exp_flit(k, 2'd1, 2'd2, 4'd9)) begin
        bad++;
        $display("FAIL midreset_flit%0d: got %h want %h", k, q[k],
                 exp_flit(k, 2'd1, 2'd2, 4'd9));
      end
    end
  endtask

  initial begin
    start      = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    w_ready_pe = 1'b0;
    dest_x     = '0;
    dest_y     = '0;
    pkt_no     = '0;
    test_reset();
    test_basic();
    test_toggle_gaps();
    test_back_to_back_stall();
    test_start_ignored();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
